cam_pixel_capture: RTL

// Camera front-end stage feeding the colour classifier. It samples an
// OV7670-style 8-bit parallel bus (pclk/href/vsync/data, RGB565, two bytes
// per pixel) in the clk domain. It assembles each pixel into 15-bit RGB555
// {R[4:0],G[5:1],B[4:0]}, so bit14/bit9/bit4 are the R/G/B MSBs, and drives

---
 rtl/cam_pixel_capture.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/cam_pixel_capture.sv
// Samples an OV7670-style RGB565 byte bus and emits RGB555 pixels with
// a one-cycle read_color strobe and a linear frame-buffer address.
//
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   cam_pclk     camera pixel clock, sampled asynchronously
//   cam_href     line valid
//   cam_vsync    frame sync
//   cam_data     camera byte
//   pixel_data   RGB555 pixel {R[4:0],G[5:1],B[4:0]}
//   read_color   one-cycle strobe, pixel_data/pixel_addr valid
//   pixel_addr   row*H_PIXELS+col of the strobed pixel
//   frame_start  pulse when the active region of a frame opens
//   frame_done   pulse when vsync rises after an active frame
//   line_cnt     lines accepted so far in this frame
module cam_pixel_capture #(
  parameter int H_PIXELS = 160,
  parameter int V_LINES  = 120,
  parameter int ADDR_W   = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cam_pclk,
  input  logic              cam_href,
  input  logic              cam_vsync,
  input  logic [7:0]        cam_data,
  output logic [14:0]       pixel_data,
  output logic              read_color,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic              frame_start,
  output logic              frame_done,
  output logic [7:0]        line_cnt
);

  localparam int COL_W = $clog2(H_PIXELS + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_VSYNC = 2'd1;
  localparam logic [1:0] S_HI    = 2'd2;
  localparam logic [1:0] S_LO    = 2'd3;

  logic [1:0]       pclk_sy;
  logic [1:0]       href_sy;
  logic [1:0]       vsync_sy;
  logic [7:0]       data_m;
  logic [7:0]       data_s;
  logic             pclk_prev;
  logic             href_prev;
  logic             vsync_prev;

  logic             pclk_s;
  logic             href_s;
  logic             vsync_s;
  logic             pclk_rise;
  logic             href_fall;
  logic             vsync_rise;
  logic             vsync_fall;

  logic [1:0]       state;
  logic [COL_W-1:0] col;
  logic [7:0]       hi_byte;
  logic             col_ok;
  logic             line_ok;
  logic [14:0]      pix;
  logic [ADDR_W-1:0] addr_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      pclk_sy    <= '0;
      href_sy    <= '0;
      vsync_sy   <= '0;
      data_m     <= '0;
      data_s     <= '0;
      pclk_prev  <= 1'b0;
      href_prev  <= 1'b0;
      vsync_prev <= 1'b0;
    end else begin
      pclk_sy    <= {pclk_sy[0], cam_pclk};
      href_sy    <= {href_sy[0], cam_href};
      vsync_sy   <= {vsync_sy[0], cam_vsync};
      data_m     <= cam_data;
      data_s     <= data_m;
      pclk_prev  <= pclk_sy[1];
      href_prev  <= href_sy[1];
      vsync_prev <= vsync_sy[1];
    end
  end

  assign pclk_s     = pclk_sy[1];
  assign href_s     = href_sy[1];
  assign vsync_s    = vsync_sy[1];
  assign pclk_rise  = pclk_s & ~pclk_prev;
  assign href_fall  = href_prev & ~href_s;
  assign vsync_rise = vsync_s & ~vsync_prev;
  assign vsync_fall = vsync_prev & ~vsync_s;

  // col saturates at H_PIXELS; only "col < H_PIXELS" matters past there
  assign col_ok  = (col < COL_W'(H_PIXELS));
  assign line_ok = (line_cnt < 8'(V_LINES));

  // hi byte = R[4:0],G[5:3]; lo byte = G[2:0],B[4:0]; G[0] is dropped
  assign pix = {hi_byte, data_s[7:6], data_s[4:0]};

  assign addr_next = ADDR_W'(line_cnt) * ADDR_W'(H_PIXELS)
                   + ADDR_W'(col);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pixel_data  <= '0;
      read_color  <= 1'b0;
      pixel_addr  <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      line_cnt    <= '0;
      col         <= '0;
      hi_byte     <= '0;
    end else begin
      read_color  <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (vsync_s) state <= S_VSYNC;
        end
        S_VSYNC: begin
          if (vsync_fall) begin
            frame_start <= 1'b1;
            col         <= '0;
            line_cnt    <= '0;
            pixel_addr  <= '0;
            state       <= S_HI;
          end
        end
        S_HI, S_LO: begin
          // vsync rise outranks a coincident pclk edge
          if (vsync_rise) begin
            frame_done <= 1'b1;
            state      <= S_VSYNC;
          end else if (href_fall) begin
            if (col != '0 && line_ok)
              line_cnt <= line_cnt + 8'd1;
            col   <= '0;
            state <= S_HI;
          end else if (pclk_rise && href_s) begin
            if (state == S_HI) begin
              hi_byte <= data_s;
              state   <= S_LO;
            end else begin
              if (col_ok && line_ok) begin
                pixel_data <= pix;
                pixel_addr <= addr_next;
                read_color <= 1'b1;
              end
              if (col_ok) col <= col + COL_W'(1);
              state <= S_HI;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
